// File: rtl/nes_pad_pkg.sv
// Shared definitions for the NES/SNES pad link, used by both the pad responder
// and the console-side receiver.
package nes_pad_pkg;

    localparam int NUM_BUTTONS = 12;
    localparam int SR_W        = 16;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    localparam int NES_FRAME_LEN  = 8;
    localparam int SNES_FRAME_LEN = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } pad_state_e;

    // Frame image as loaded into the pad shift register (1 = pressed, bit 0 goes out first).
    // NES pads put A first and fill the tail with pressed bits; SNES pads end
    // with a released ID nibble.
    function automatic logic [SR_W-1:0] load_frame(input logic [NUM_BUTTONS-1:0] btn,
                                                   input logic                   snes);
        logic [SR_W-1:0] frame;
        if (snes) begin
            frame = {4'b0000, btn};
        end else begin
            frame = {8'hFF,
                     btn[BTN_RIGHT], btn[BTN_LEFT], btn[BTN_DOWN], btn[BTN_UP],
                     btn[BTN_START], btn[BTN_SELECT], btn[BTN_B], btn[BTN_A]};
        end
        return frame;
    endfunction

endpackage

// File: rtl/pad_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pad pin, followed by an extra
// flop that turns level changes into single-cycle rise/fall pulses.
module pad_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/nes_pad_responder.sv
// Pad-side end of the NES/SNES serial protocol: answers console latch/clock
// pulses with an active-low button stream built from a 12-bit button vector.
//
//   state | meaning
//   IDLE  | after reset, shift register held
//   LOAD  | latch high, shift register reloaded every cycle, bit_count cleared
//   SHIFT | frame in progress, each pad_clk rise shifts one bit out
//   DONE  | frame complete, further clocks shift in 1s (line stays low)
module nes_pad_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] buttons,
    input  logic        snes_mode,
    input  logic        pad_latch,
    input  logic        pad_clk,
    output logic        pad_data,
    output logic [4:0]  bit_count,
    output logic        poll_done,
    output logic [7:0]  poll_count
);

    import nes_pad_pkg::*;

    localparam logic [4:0] COUNT_SAT = 5'(SNES_FRAME_LEN);

    pad_state_e      state_q, state_d;
    logic [SR_W-1:0] sr_q, sr_d;
    logic [4:0]      bit_count_q, bit_count_d;
    logic            poll_done_q, poll_done_d;
    logic [7:0]      poll_count_q, poll_count_d;
    logic            snes_q, snes_d;
    logic [4:0]      frame_len;

    logic latch_level, latch_fall, latch_rise_unused;
    logic clk_rise, clk_level_unused, clk_fall_unused;

    pad_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_latch_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (pad_latch),
        .level (latch_level),
        .rise  (latch_rise_unused),
        .fall  (latch_fall)
    );

    // pad_clk idles high, so its synchroniser resets high to avoid a fake rise.
    pad_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_clk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (pad_clk),
        .level (clk_level_unused),
        .rise  (clk_rise),
        .fall  (clk_fall_unused)
    );

    assign frame_len = snes_q ? 5'(SNES_FRAME_LEN) : 5'(NES_FRAME_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            bit_count_q  <= '0;
            poll_done_q  <= 1'b0;
            poll_count_q <= '0;
            snes_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_count_q  <= bit_count_d;
            poll_done_q  <= poll_done_d;
            poll_count_q <= poll_count_d;
            snes_q       <= snes_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_count_d  = bit_count_q;
        poll_done_d  = 1'b0;
        poll_count_d = poll_count_q;
        snes_d       = snes_q;

        // A high latch overrides everything, including an in-flight frame.
        if (latch_level) begin
            state_d     = LOAD;
            sr_d        = load_frame(buttons, snes_mode);
            bit_count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: ;
                LOAD: begin
                    if (latch_fall) begin
                        state_d = SHIFT;
                        snes_d  = snes_mode;
                    end
                end
                SHIFT: begin
                    if (bit_count_q == frame_len) begin
                        state_d      = DONE;
                        poll_done_d  = 1'b1;
                        poll_count_d = poll_count_q + 8'd1;
                    end else if (clk_rise) begin
                        sr_d = {1'b1, sr_q[SR_W-1:1]};
                        if (bit_count_q != COUNT_SAT) bit_count_d = bit_count_q + 5'd1;
                    end
                end
                DONE: begin
                    if (clk_rise) begin
                        sr_d = {1'b1, sr_q[SR_W-1:1]};
                        if (bit_count_q != COUNT_SAT) bit_count_d = bit_count_q + 5'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign pad_data   = ~sr_q[0];
    assign bit_count  = bit_count_q;
    assign poll_done  = poll_done_q;
    assign poll_count = poll_count_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder acting as a console: latch/clock pulses,
// serial reads and hand-computed expected bit streams.
module tb_nes_pad_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] buttons;
    logic        snes_mode;
    logic        pad_latch;
    logic        pad_clk;
    logic        pad_data;
    logic [4:0]  bit_count;
    logic        poll_done;
    logic [7:0]  poll_count;

    int n_checks    = 0;
    int n_fail      = 0;
    int done_pulses = 0;
    int lat;

    nes_pad_responder #(.SYNC_STAGES(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .buttons    (buttons),
        .snes_mode  (snes_mode),
        .pad_latch  (pad_latch),
        .pad_clk    (pad_clk),
        .pad_data   (pad_data),
        .bit_count  (bit_count),
        .poll_done  (poll_done),
        .poll_count (poll_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (poll_done === 1'b1) done_pulses++;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic latch_pulse();
        @(negedge clk); pad_latch = 1'b1;
        cycles(10);
        @(negedge clk); pad_latch = 1'b0;
        cycles(10);
    endtask

    task automatic clock_pulse();
        @(negedge clk); pad_clk = 1'b0;
        cycles(10);
        @(negedge clk); pad_clk = 1'b1;
        cycles(10);
    endtask

    // Console-style read: sample the pressed flag, then clock the next bit in.
    task automatic read_bits(input int first, input int n, input logic [15:0] exp, input string tag);
        logic pressed;
        for (int i = first; i < first + n; i++) begin
            @(negedge clk);
            pressed = ~pad_data;
            check_val($sformatf("%s_bit%0d", tag, i), {31'd0, pressed}, {31'd0, exp[i]});
            clock_pulse();
        end
    endtask

    // Pin edge already driven; count clk edges until pad_data reaches target.
    task automatic measure(input logic target, output int edges);
        edges = 99;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (pad_data === target) begin
                edges = k;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        buttons   = '0;
        snes_mode = 1'b0;
        pad_latch = 1'b0;
        pad_clk   = 1'b1;
        cycles(3);
        @(negedge clk);
        check_val("rst_pad_data",   {31'd0, pad_data},  32'd1);
        check_val("rst_bit_count",  {27'd0, bit_count}, 32'd0);
        check_val("rst_poll_done",  {31'd0, poll_done}, 32'd0);
        check_val("rst_poll_count", {24'd0, poll_count}, 32'd0);
        rst_n = 1'b1;
        cycles(5);

        // NES poll, A + Right: pressed flags A,B,Sel,Start,Up,Down,Left,Right = 1,0,0,0,0,0,0,1
        buttons = 12'h180; snes_mode = 1'b0;
        latch_pulse();
        read_bits(0, 8, 16'h0081, "nes");
        @(negedge clk);
        check_val("nes_done_pulses", done_pulses, 32'd1);
        check_val("nes_poll_count",  {24'd0, poll_count}, 32'd1);
        check_val("nes_bit_count",   {27'd0, bit_count}, 32'd8);
        check_val("nes_tail_low",    {31'd0, pad_data},  32'd0);

        // Overrun: 12 extra clocks push bit_count past 16 into saturation
        for (int i = 0; i < 12; i++) begin
            clock_pulse();
            @(negedge clk);
            check_val($sformatf("over_data%0d", i), {31'd0, pad_data}, 32'd0);
        end
        check_val("over_bit_count",   {27'd0, bit_count}, 32'd16);
        check_val("over_done_pulses", done_pulses, 32'd1);
        check_val("over_poll_count",  {24'd0, poll_count}, 32'd1);

        // SNES poll, all pressed; pad_clk toggled while latch high must be ignored
        buttons = 12'hFFF; snes_mode = 1'b1;
        @(negedge clk); pad_latch = 1'b1;
        cycles(10);
        clock_pulse();
        @(negedge clk);
        check_val("latch_clk_ignored", {27'd0, bit_count}, 32'd0);
        pad_latch = 1'b0;
        cycles(10);
        snes_mode = 1'b0;
        read_bits(0, 8, 16'h0FFF, "snes");
        check_val("snes_no_early_done", done_pulses, 32'd1);
        read_bits(8, 8, 16'h0FFF, "snes");
        @(negedge clk);
        check_val("snes_done_pulses", done_pulses, 32'd2);
        check_val("snes_poll_count",  {24'd0, poll_count}, 32'd2);
        check_val("snes_bit_count",   {27'd0, bit_count}, 32'd16);

        // Abort after 3 SNES clocks; restart must present B again
        buttons = 12'h001; snes_mode = 1'b1;
        latch_pulse();
        clock_pulse(); clock_pulse(); clock_pulse();
        @(negedge clk);
        check_val("abort_pre_count", {27'd0, bit_count}, 32'd3);
        check_val("abort_pre_data",  {31'd0, pad_data},  32'd1);
        latch_pulse();
        @(negedge clk);
        check_val("abort_done_pulses", done_pulses, 32'd2);
        check_val("abort_bit_count",   {27'd0, bit_count}, 32'd0);
        check_val("abort_restart_b",   {31'd0, pad_data},  32'd0);
        check_val("abort_poll_count",  {24'd0, poll_count}, 32'd2);

        // Sync latency with 3 stages: pin edge mid-cycle -> change on the 4th clk edge
        buttons = 12'h104; snes_mode = 1'b0;
        latch_pulse();
        @(negedge clk);
        check_val("lat_bit0", {31'd0, pad_data}, 32'd0);
        @(negedge clk); pad_clk = 1'b0;
        cycles(10);
        @(negedge clk); pad_clk = 1'b1;
        measure(1'b1, lat);
        check_val("lat_negedge_pin", lat, 32'd4);
        cycles(10);
        @(negedge clk); pad_clk = 1'b0;
        cycles(10);
        @(posedge clk); #1; pad_clk = 1'b1;
        measure(1'b0, lat);
        check_val("lat_posedge_pin", lat, 32'd4);
        cycles(10);

        // Asynchronous reset in the middle of a frame
        buttons = 12'hFFF; snes_mode = 1'b0;
        latch_pulse();
        clock_pulse(); clock_pulse();
        @(negedge clk);
        check_val("pre_reset_data",       {31'd0, pad_data},   32'd0);
        check_val("pre_reset_poll_count", {24'd0, poll_count}, 32'd2);
        #2; rst_n = 1'b0;
        #1;
        check_val("async_rst_pad_data",   {31'd0, pad_data},   32'd1);
        check_val("async_rst_bit_count",  {27'd0, bit_count},  32'd0);
        check_val("async_rst_poll_count", {24'd0, poll_count}, 32'd0);
        check_val("async_rst_poll_done",  {31'd0, poll_done},  32'd0);
        rst_n = 1'b1;
        cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
